ref_win_loader: RTL

REF_WIN_LOADER -- requirements
Module: ref_win_loader

---
 rtl/ref_win_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ref_win_loader.sv
// ref_win_loader: streams one 8-group x 96-row search window from external memory into the reference RAM.
// Optional REF_LOADER_STALL_CNT_EN adds o_stall_cnt (write-side backpressure cycles during LOAD).
module ref_win_loader #(
    parameter int DATA_W  = 256,
    parameter int CREDITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [23:0]       i_base_addr,
    input  logic [23:0]       i_line_stride,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_req,
    output logic [23:0]       o_rd_addr,
    input  logic              i_rd_gnt,
    input  logic              i_rd_vld,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_wr_vld,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [2:0]        o_wr_group,
    output logic [6:0]        o_wr_row,
    input  logic              i_wr_rdy
`ifdef REF_LOADER_STALL_CNT_EN
    ,output logic [15:0]      o_stall_cnt
`endif
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int AW = CREDITS > 1 ? $clog2(CREDITS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
    state_t            r_state, w_next;
    logic [23:0]       r_base, r_stride, r_row_off;
    logic [9:0]        r_iss_cnt, r_wr_cnt;
    logic [6:0]        r_iss_row, r_wr_row;
    logic [2:0]        r_iss_grp, r_wr_grp;
    logic [CW-1:0]     r_outst, r_fcnt;
    logic [AW-1:0]     r_wp, r_rp;
    logic [DATA_W-1:0] r_mem [CREDITS];
    logic              w_take, w_rd_req, w_iss, w_push, w_wr_vld, w_pop, w_last;
    assign w_take   = (r_state == S_IDLE) && i_start;
    // Outstanding reads plus buffered words never exceed the FIFO depth, so a return always has a slot.
    assign w_rd_req = (r_state == S_LOAD) && (r_iss_cnt < 10'd768) &&
                      (({1'b0, r_outst} + {1'b0, r_fcnt}) < (CW + 1)'(CREDITS));
    assign w_iss    = w_rd_req && i_rd_gnt;
    assign w_push   = i_rd_vld && (r_outst != '0);
    assign w_wr_vld = r_fcnt != '0;
    assign w_pop    = w_wr_vld && i_wr_rdy;
    assign w_last   = w_pop && (r_wr_cnt == 10'd767);
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = w_last ? S_DONE : S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base    <= '0;
            r_stride  <= '0;
            r_row_off <= '0;
            r_iss_cnt <= '0;
            r_iss_row <= '0;
            r_iss_grp <= '0;
            r_wr_cnt  <= '0;
            r_wr_row  <= '0;
            r_wr_grp  <= '0;
            r_outst   <= '0;
            r_fcnt    <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
        end else begin
            if (w_take) begin
                r_base    <= i_base_addr;
                r_stride  <= i_line_stride;
                r_row_off <= '0;
                r_iss_cnt <= '0;
                r_iss_row <= '0;
                r_iss_grp <= '0;
                r_wr_cnt  <= '0;
                r_wr_row  <= '0;
                r_wr_grp  <= '0;
            end
            // Row offset is accumulated instead of multiplied; it restarts at each new group.
            if (w_iss) begin
                r_iss_cnt <= r_iss_cnt + 10'd1;
                r_iss_row <= (r_iss_row == 7'd95) ? 7'd0 : r_iss_row + 7'd1;
                r_row_off <= (r_iss_row == 7'd95) ? 24'd0 : r_row_off + r_stride;
                r_iss_grp <= (r_iss_row == 7'd95) ? r_iss_grp + 3'd1 : r_iss_grp;
            end
            if (w_push)
                r_wp <= (r_wp == AW'(CREDITS - 1)) ? '0 : r_wp + 1'b1;
            if (w_pop) begin
                r_rp     <= (r_rp == AW'(CREDITS - 1)) ? '0 : r_rp + 1'b1;
                r_wr_cnt <= r_wr_cnt + 10'd1;
                r_wr_row <= (r_wr_row == 7'd95) ? 7'd0 : r_wr_row + 7'd1;
                r_wr_grp <= (r_wr_row == 7'd95) ? r_wr_grp + 3'd1 : r_wr_grp;
            end
            r_outst <= r_outst + CW'(w_iss) - CW'(w_push);
            r_fcnt  <= r_fcnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= i_rd_data;
    end
    assign o_busy     = r_state != S_IDLE;
    assign o_done     = r_state == S_DONE;
    assign o_rd_req   = w_rd_req;
    assign o_rd_addr  = r_base + r_row_off + 24'(r_iss_grp);
    assign o_wr_vld   = w_wr_vld;
    assign o_wr_data  = w_wr_vld ? r_mem[r_rp] : '0;
    assign o_wr_group = r_wr_grp;
    assign o_wr_row   = r_wr_row;
`ifdef REF_LOADER_STALL_CNT_EN
    logic [15:0] r_stall;
    always_ff @(posedge clk) begin
        if (rst || w_take)
            r_stall <= '0;
        else if ((r_state == S_LOAD) && w_wr_vld && !i_wr_rdy && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end
    assign o_stall_cnt = r_stall;
`endif
endmodule
